// File: rtl/operand_fetch_sb.sv
// Operand fetch stage with per-register pending-write scoreboard.
// Reads rs1/rs2, bypasses the live writeback, stalls decode on RAW or counter saturation.
module operand_fetch_sb #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_wr,
  output logic [4:0]      read_r1,
  output logic [4:0]      read_r2,
  input  logic [XLEN-1:0] data_r1,
  input  logic [XLEN-1:0] data_r2,
  input  logic            RegWriteEn,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [4:0]      ex_rd,
  output logic            ex_wr,
  output logic            sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] pend_q [32];
  logic [CNT_W-1:0] pend_d [32];
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_op1_q, ex_op1_d, ex_op2_q, ex_op2_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_wr_q, ex_wr_d;
  logic             sb_err_q, sb_err_d;

  logic            wb_en, hit_rs1, hit_rs2, hit_rd;
  logic            blk_rs1, blk_rs2, blk_rd;
  logic            slot_free, issue;
  logic [XLEN-1:0] op1, op2;

  assign read_r1 = id_rs1;
  assign read_r2 = id_rs2;

  assign wb_en   = RegWriteEn && (rd != 5'd0);
  assign hit_rs1 = wb_en && (rd == id_rs1);
  assign hit_rs2 = wb_en && (rd == id_rs2);
  assign hit_rd  = wb_en && (rd == id_rd);

  assign op1 = (id_rs1 == 5'd0) ? '0 : (hit_rs1 ? data : data_r1);
  assign op2 = (id_rs2 == 5'd0) ? '0 : (hit_rs2 ? data : data_r2);

  // A single outstanding write that lands this cycle is satisfied by the bypass.
  assign blk_rs1 = id_use_rs1 && (id_rs1 != 5'd0) && (pend_q[id_rs1] != '0)
                   && !(hit_rs1 && (pend_q[id_rs1] == CNT_ONE));
  assign blk_rs2 = id_use_rs2 && (id_rs2 != 5'd0) && (pend_q[id_rs2] != '0)
                   && !(hit_rs2 && (pend_q[id_rs2] == CNT_ONE));
  assign blk_rd  = id_wr && (id_rd != 5'd0) && (pend_q[id_rd] == CNT_MAX) && !hit_rd;

  assign slot_free = !ex_valid_q || ex_ready;
  assign id_ready  = slot_free && !(blk_rs1 || blk_rs2 || blk_rd);
  assign issue     = id_valid && id_ready;

  always_comb begin
    for (int r = 0; r < 32; r++) pend_d[r] = pend_q[r];
    for (int r = 1; r < 32; r++) begin
      if ((issue && id_wr && (id_rd == 5'(r))) &&
          !(wb_en && (rd == 5'(r)) && (pend_q[r] != '0)))
        pend_d[r] = pend_q[r] + CNT_ONE;
      else if (!(issue && id_wr && (id_rd == 5'(r))) &&
               (wb_en && (rd == 5'(r)) && (pend_q[r] != '0)))
        pend_d[r] = pend_q[r] - CNT_ONE;
    end
  end

  assign sb_err_d = sb_err_q || (wb_en && (pend_q[rd] == '0));

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op1_d   = ex_op1_q;
    ex_op2_d   = ex_op2_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_d    = ex_wr_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_op1_d   = op1;
      ex_op2_d   = op2;
      ex_rd_d    = id_rd;
      ex_wr_d    = id_wr;
    end else if (ex_valid_q && ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) pend_q[r] <= '0;
      ex_valid_q <= 1'b0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_rd_q    <= '0;
      ex_wr_q    <= 1'b0;
      sb_err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) pend_q[r] <= pend_d[r];
      ex_valid_q <= ex_valid_d;
      ex_op1_q   <= ex_op1_d;
      ex_op2_q   <= ex_op2_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_q    <= ex_wr_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_op1   = ex_op1_q;
  assign ex_op2   = ex_op2_q;
  assign ex_rd    = ex_rd_q;
  assign ex_wr    = ex_wr_q;
  assign sb_err   = sb_err_q;

endmodule

// File: doc/operand_fetch_sb.md
Name: operand_fetch_sb

Overview:
- Register-file reader side of the datapath: issues rs1/rs2 read addresses to Banco_Registros and captures operands for execute.
- Tracks in-flight writes with a per-register scoreboard, bypasses the current writeback value, and stalls decode on RAW hazards.
- Snoops the same RegWriteEn/rd/data bus that writes the register file.
- Sits between decode and execute, feeding a registered operand stage.

Parameters:
- XLEN, 32, operand/data width.
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  instruction accepted this cycle.
- id_rs1, id_rs2  in  5  source registers.
- id_use_rs1, id_use_rs2  in  1  source is actually read.
- id_rd  in  5  destination register.
- id_wr  in  1  instruction will write id_rd.
- read_r1, read_r2  out  5  register-file read addresses.
- data_r1, data_r2  in  XLEN  register-file read data (combinational, pre-write contents).
- RegWriteEn  in  1  writeback strobe (same net as register file).
- rd  in  5  writeback register.
- data  in  XLEN  writeback data.
- ex_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute accepts.
- ex_op1, ex_op2  out  XLEN  captured operands.
- ex_rd  out  5; ex_wr  out  1  forwarded destination info.
- sb_err  out  1  sticky: writeback to a register with pending count 0.

Behaviour:
- Reset (rst=0, async): every pending counter 0, ex_valid=0, ex_op1=ex_op2=0, ex_rd=0, ex_wr=0, sb_err=0.
- read_r1=id_rs1 and read_r2=id_rs2, combinational at all times.
- wb_hit(r): RegWriteEn && rd==r && r!=0.
- Operand select, per source:
  - x0 reads 0.
  - else if wb_hit, take data.
  - else take data_r1/data_r2.
- Source blocked when all hold: used, nonzero, pend[r]!=0, and NOT (wb_hit(r) && pend[r]==1).
  - Pending >1 with writeback hit still blocks: an older write lands first and the youngest value is not yet available.
- Destination blocked when id_wr && id_rd!=0 && pend[id_rd]==2^CNT_W-1 && !wb_hit(id_rd).
- slot_free = !ex_valid || ex_ready.
- id_ready = slot_free && !any_block; asserted independently of id_valid.
- Issue = id_valid && id_ready. On the issuing edge:
  - ex_op1/ex_op2/ex_rd/ex_wr are loaded.
  - ex_valid=1.
  - If id_wr && id_rd!=0, pend[id_rd] increments.
- Execute handshake: ex_valid && ex_ready && !issue -> ex_valid=0. Outputs hold while ex_valid && !ex_ready.
- Latency: one cycle, accept to ex_valid. Full throughput, one per cycle, with no hazards.
- Writeback: wb_hit(r) with pend[r]>0 decrements pend[r].
  - With pend[r]==0: no change, sb_err=1 until reset.
  - RegWriteEn with rd=0 is ignored entirely.
- Same-register issue and writeback in one cycle: net counter change 0. Never two updates applied sequentially.
- Operands never reflect the issuing instruction's own write.
- id_wr with id_rd=0 is never tracked.
- Counters never wrap: saturation is prevented by the destination-block stall.

Test Plan:
- Reset mid-stream: ex_valid=1, pend[5]=2, then rst low for 3 ns, no clock edge -> ex_valid=0, all pending=0, sb_err=0 immediately.
- Independent issue: x1=45 and x2=7 preloaded. Issue add rs1=1, rs2=2, rd=3 -> next cycle ex_op1=45, ex_op2=7, ex_rd=3, pend[3]=1, id_ready stays 1.
- RAW stall and bypass: issue rd=3, then rs1=3 -> id_ready=0 until cycle with RegWriteEn=1, rd=3, data=100. That cycle id_ready=1; next cycle ex_op1=100, pend[3]=0.
- Multiple in flight: three issues to rd=4 -> pend=3. Fourth issue to rd=4 stalls. With one writeback rd=4 that same cycle, it issues and pend stays 3. Reader of x4 blocked until pend==1 with hit.
- Backpressure: ex_ready=0 for 4 cycles with ex_valid=1 -> ex_op1/ex_op2 stable, id_ready=0. ex_ready=1 -> next queued instruction loads on that edge.
- x0 and error: rs1=0 while RegWriteEn=1, rd=0, data=0xFFFFFFFF -> ex_op1=0, no counter change. Writeback rd=9 with pend[9]=0 -> sb_err=1 and stays 1.
